// File: rtl/tz_periph_arbiter.sv
// Secure/non-secure write-path arbiter for the TrustZone peripheral.
// Optional secure lock enabled by defining TZ_ARB_LOCK_EN.
module tz_periph_arbiter #(
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_req,
    input  logic [DW-1:0] s_wdata,
    input  logic          s_lock,
    output logic          s_gnt,
    input  logic          ns_req,
    input  logic [DW-1:0] ns_wdata,
    output logic          ns_gnt,
    output logic          ns_err,
    output logic          p_wvalid,
    output logic [DW-1:0] p_wdata,
    output logic          p_wsec,
    input  logic          p_wready,
    output logic          lock_active
);

`ifdef TZ_ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e          state;
    logic [CntW-1:0] wait_cnt;
    logic            owner_lock;
    logic            lock_q;
    logic            err_q;
    logic            locked;
    logic            starve;

    assign locked      = LockEn && lock_q;
    assign starve      = (wait_cnt == CntW'(MAX_WAIT));
    assign lock_active = lock_q;
    assign ns_err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            wait_cnt   <= '0;
            owner_lock <= 1'b0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            s_gnt      <= 1'b0;
            ns_gnt     <= 1'b0;
            p_wvalid   <= 1'b0;
            p_wdata    <= '0;
            p_wsec     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    s_gnt  <= 1'b0;
                    ns_gnt <= 1'b0;
                    err_q  <= 1'b0;
                    // Secure wins unless the non-secure side has starved; the lock overrides starvation.
                    if (s_req && (locked || !ns_req || !starve)) begin
                        p_wdata    <= s_wdata;
                        p_wsec     <= 1'b1;
                        p_wvalid   <= 1'b1;
                        owner_lock <= s_lock & LockEn;
                        state      <= StXfer;
                        if (!ns_req) begin
                            wait_cnt <= '0;
                        end else if (!locked && !starve) begin
                            wait_cnt <= wait_cnt + CntW'(1);
                        end
                    end else if (ns_req) begin
                        wait_cnt <= '0;
                        if (locked) begin
                            ns_gnt <= 1'b1;
                            err_q  <= 1'b1;
                            state  <= StDone;
                        end else begin
                            p_wdata    <= ns_wdata;
                            p_wsec     <= 1'b0;
                            p_wvalid   <= 1'b1;
                            owner_lock <= 1'b0;
                            state      <= StXfer;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                StXfer: begin
                    if (p_wready) begin
                        p_wvalid <= 1'b0;
                        state    <= StDone;
                        if (p_wsec) begin
                            s_gnt  <= 1'b1;
                            lock_q <= owner_lock;
                        end else begin
                            ns_gnt <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    s_gnt  <= 1'b0;
                    ns_gnt <= 1'b0;
                    err_q  <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
